// File: rtl/control_types_pkg.sv
// Per-cycle datapath control word plus the sequencer's instruction-class and state types.
package control_types_pkg;

    typedef enum logic [2:0] {
        B_NONE      = 3'd0,
        B_IMM       = 3'd1,
        B_REG_RM    = 3'd2,
        B_REG_RS    = 3'd3,
        B_REG_RD    = 3'd4,
        B_READ_DATA = 3'd5
    } b_src_t;

    typedef enum logic [1:0] {
        SH_SRC_NONE = 2'd0,
        SH_SRC_IMM  = 2'd1,
        SH_SRC_REG  = 2'd2
    } sh_src_t;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'd0,
        SHIFT_LSR = 2'd1,
        SHIFT_ASR = 2'd2,
        SHIFT_ROR = 2'd3
    } shift_t;

    // Matches the ARM data-processing opcode field.
    typedef enum logic [3:0] {
        ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
        ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7,
        ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB,
        ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF
    } alu_op_t;

    typedef enum logic [1:0] {
        ALU_WB_NONE   = 2'd0,
        ALU_WB_REG_RD = 2'd1,
        ALU_WB_REG_RN = 2'd2
    } alu_wb_t;

    typedef enum logic [1:0] {
        ADDR_NONE = 2'd0,
        ADDR_PC   = 2'd1,
        ADDR_ALU  = 2'd2
    } addr_src_t;

    typedef struct packed {
        b_src_t     b_bus_source;
        logic [11:0] b_bus_imm;
        sh_src_t    shift_source;
        shift_t     shift_type;
        logic [4:0] shift_amount;
        logic       latch_shift_amt;
        logic       use_shift_latch;
        alu_op_t    alu_op;
        logic       set_alu_flags;
        alu_wb_t    alu_writeback;
        addr_src_t  addr_bus_src;
        logic       incrementer_writeback;
        logic       memory_write_en;
    } control_t;

    localparam control_t CTRL_NOP = '0;

    typedef enum logic [2:0] {
        CLS_DP_IMM = 3'd0,
        CLS_DP_RSI = 3'd1,
        CLS_DP_RSR = 3'd2,
        CLS_LDR    = 3'd3,
        CLS_STR    = 3'd4,
        CLS_UNDEF  = 3'd5
    } instr_class_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STEP0   = 3'd1,
        ST_STEP1   = 3'd2,
        ST_MEMWAIT = 3'd3,
        ST_WB      = 3'd4
    } seq_state_t;

    // Fields common to every data-processing execute step; op_s is instr[24:20].
    function automatic control_t dp_base(input logic [4:0] op_s);
        control_t c;
        c                       = CTRL_NOP;
        c.alu_op                = alu_op_t'(op_s[4:1]);
        c.set_alu_flags         = op_s[0];
        // TST/TEQ/CMP/CMN only update flags
        c.alu_writeback         = (op_s[4:3] == 2'b10) ? ALU_WB_NONE : ALU_WB_REG_RD;
        c.addr_bus_src          = ADDR_PC;
        c.incrementer_writeback = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/arm7_instr_classify.sv
// Combinational decode of an ARM instruction word into a sequencer instruction class.
module arm7_instr_classify
    import control_types_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t instr_class
);

    logic unused_instr;
    assign unused_instr = ^{instr[31:28], instr[24:21], instr[19:8], instr[6:5], instr[3:0]};

    always_comb begin
        instr_class = CLS_UNDEF;
        case (instr[27:25])
            3'b001: instr_class = CLS_DP_IMM;
            3'b000: begin
                if (!instr[4])      instr_class = CLS_DP_RSI;
                else if (!instr[7]) instr_class = CLS_DP_RSR;
            end
            3'b010: instr_class = instr[20] ? CLS_LDR : CLS_STR;
            // Register-offset form; bit4 set here is the media/undefined space
            3'b011: begin
                if (!instr[4]) instr_class = instr[20] ? CLS_LDR : CLS_STR;
            end
            default: instr_class = CLS_UNDEF;
        endcase
    end

endmodule

// File: rtl/arm7_control_sequencer.sv
// Expands one accepted ARM instruction into a 1..N cycle sequence of control words.
// Optional ARM7_SEQ_PERF_EN adds instruction and stall performance counters.
module arm7_control_sequencer
    import control_types_pkg::*;
#(
    parameter int unsigned MEM_WAIT_STATES = 0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        cond_pass,
    output logic        instr_ready,
    input  logic        flush,
    output control_t    ctrl,
    output logic        busy,
    output logic        undef
`ifdef ARM7_SEQ_PERF_EN
    ,
    output logic [31:0] perf_instr_count,
    output logic [31:0] perf_stall_count
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_WAIT_STATES);

    seq_state_t       state;
    logic [31:0]      ir;
    logic             ir_cond;
    instr_class_t     ir_class;
    instr_class_t     dec_class;
    logic [CNT_W-1:0] wait_cnt;
    logic             nop_seq;
    logic             final_step;
    logic             accept;

    logic unused_ir;
    assign unused_ir = ^{ir[31:26], ir[19:12]};

    arm7_instr_classify u_classify (
        .instr       (instr),
        .instr_class (dec_class)
    );

    // Failed condition and undefined encodings both collapse to a single NOP step
    assign nop_seq = !ir_cond || (ir_class == CLS_UNDEF);

    always_comb begin
        final_step = 1'b0;
        case (state)
            ST_STEP0:   final_step = nop_seq || (ir_class == CLS_DP_IMM) || (ir_class == CLS_DP_RSI);
            ST_STEP1:   final_step = 1'b1;
            ST_MEMWAIT: final_step = (ir_class == CLS_STR) && (wait_cnt == '0);
            ST_WB:      final_step = 1'b1;
            default:    final_step = 1'b0;
        endcase
    end

    assign instr_ready = !flush && ((state == ST_IDLE) || final_step);
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state != ST_IDLE);
    assign undef       = (state == ST_STEP0) && (ir_class == CLS_UNDEF) && ir_cond;

    // Sequence FSM; accept on the final step chains straight into STEP0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ir       <= '0;
            ir_cond  <= 1'b0;
            ir_class <= CLS_DP_IMM;
            wait_cnt <= '0;
        end else if (flush) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else if (accept) begin
            state    <= ST_STEP0;
            ir       <= instr;
            ir_cond  <= cond_pass;
            ir_class <= dec_class;
        end else if (final_step) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_STEP0: begin
                    if (ir_class == CLS_DP_RSR) begin
                        state <= ST_STEP1;
                    end else begin
                        state    <= ST_MEMWAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                ST_MEMWAIT: begin
                    if (wait_cnt == '0) state <= ST_WB;
                    else                wait_cnt <= wait_cnt - CNT_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Control word decode from state and latched IR
    always_comb begin
        ctrl = CTRL_NOP;
        case (state)
            ST_STEP0: begin
                if (nop_seq) begin
                    ctrl.addr_bus_src          = ADDR_PC;
                    ctrl.incrementer_writeback = 1'b1;
                end else begin
                    case (ir_class)
                        CLS_DP_IMM: begin
                            ctrl              = dp_base(ir[24:20]);
                            ctrl.b_bus_source = B_IMM;
                            ctrl.b_bus_imm    = ir[11:0];
                            ctrl.shift_source = SH_SRC_IMM;
                            ctrl.shift_type   = SHIFT_ROR;
                            ctrl.shift_amount = {ir[11:8], 1'b0};
                        end
                        CLS_DP_RSI: begin
                            ctrl              = dp_base(ir[24:20]);
                            ctrl.b_bus_source = B_REG_RM;
                            ctrl.shift_source = SH_SRC_IMM;
                            ctrl.shift_type   = shift_t'(ir[6:5]);
                            ctrl.shift_amount = ir[11:7];
                        end
                        CLS_DP_RSR: begin
                            ctrl.b_bus_source    = B_REG_RS;
                            ctrl.latch_shift_amt = 1'b1;
                        end
                        CLS_LDR, CLS_STR: begin
                            if (ir[25]) begin
                                ctrl.b_bus_source = B_REG_RM;
                                ctrl.shift_source = SH_SRC_IMM;
                                ctrl.shift_type   = shift_t'(ir[6:5]);
                                ctrl.shift_amount = ir[11:7];
                            end else begin
                                ctrl.b_bus_source = B_IMM;
                                ctrl.b_bus_imm    = ir[11:0];
                            end
                            ctrl.alu_op                = ir[23] ? ALU_ADD : ALU_SUB;
                            ctrl.alu_writeback         = ir[21] ? ALU_WB_REG_RN : ALU_WB_NONE;
                            ctrl.addr_bus_src          = ADDR_ALU;
                            ctrl.incrementer_writeback = 1'b1;
                        end
                        default: ctrl = CTRL_NOP;
                    endcase
                end
            end
            ST_STEP1: begin
                ctrl                 = dp_base(ir[24:20]);
                ctrl.b_bus_source    = B_REG_RM;
                ctrl.shift_source    = SH_SRC_REG;
                ctrl.use_shift_latch = 1'b1;
                ctrl.shift_type      = shift_t'(ir[6:5]);
            end
            ST_MEMWAIT: begin
                // Loads idle on the bus; stores drive Rd and strobe write once
                if (ir_class == CLS_STR) begin
                    ctrl.b_bus_source    = B_REG_RD;
                    ctrl.memory_write_en = (wait_cnt == WAIT_INIT);
                    if (wait_cnt == '0) ctrl.addr_bus_src = ADDR_PC;
                end
            end
            ST_WB: begin
                ctrl.b_bus_source  = B_READ_DATA;
                ctrl.alu_op        = ALU_MOV;
                ctrl.alu_writeback = ALU_WB_REG_RD;
                ctrl.addr_bus_src  = ADDR_PC;
            end
            default: ctrl = CTRL_NOP;
        endcase
        if (flush) ctrl = CTRL_NOP;
    end

`ifdef ARM7_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_instr_count <= '0;
            perf_stall_count <= '0;
        end else begin
            if (accept)                perf_instr_count <= perf_instr_count + 32'd1;
            if (busy && !instr_ready)  perf_stall_count <= perf_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arm7_control_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle expectations, a negedge monitor checks them.
module tb_arm7_control_sequencer;
    import control_types_pkg::*;

    localparam int unsigned WAITS = 2;

    typedef struct packed {
        logic [7:0] id;
        control_t   ctrl;
        logic       ready;
        logic       busy;
        logic       undef;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        cond_pass;
    logic        instr_ready;
    logic        flush;
    control_t    ctrl;
    logic        busy;
    logic        undef;
`ifdef ARM7_SEQ_PERF_EN
    logic [31:0] perf_instr_count;
    logic [31:0] perf_stall_count;
`endif

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    arm7_control_sequencer #(.MEM_WAIT_STATES(WAITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .cond_pass   (cond_pass),
        .instr_ready (instr_ready),
        .flush       (flush),
        .ctrl        (ctrl),
        .busy        (busy),
        .undef       (undef)
`ifdef ARM7_SEQ_PERF_EN
        ,
        .perf_instr_count (perf_instr_count),
        .perf_stall_count (perf_stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with a pending expectation is compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ctrl !== e.ctrl || instr_ready !== e.ready || busy !== e.busy || undef !== e.undef) begin
                errors++;
                $display("FAIL step%0d: got ctrl=%h ready=%b busy=%b undef=%b, expected ctrl=%h ready=%b busy=%b undef=%b",
                         e.id, ctrl, instr_ready, busy, undef, e.ctrl, e.ready, e.busy, e.undef);
            end
        end
    end

    function automatic exp_t mk(input logic [7:0] id, input control_t c, input logic r,
                                input logic b, input logic u);
        exp_t e;
        e.id = id; e.ctrl = c; e.ready = r; e.busy = b; e.undef = u;
        return e;
    endfunction

    task automatic cyc(input logic v, input logic [31:0] i, input logic c, input logic f,
                       input exp_t e);
        @(posedge clk);
        #1;
        instr_valid = v; instr = i; cond_pass = c; flush = f;
        exp_q.push_back(e);
    endtask

    function automatic control_t w_dp(input alu_op_t op, input logic s, input alu_wb_t wb);
        control_t c;
        c = CTRL_NOP;
        c.alu_op = op; c.set_alu_flags = s; c.alu_writeback = wb;
        c.addr_bus_src = ADDR_PC; c.incrementer_writeback = 1'b1;
        return c;
    endfunction

    function automatic control_t w_imm(input alu_op_t op, input logic s, input alu_wb_t wb,
                                       input logic [11:0] imm, input logic [4:0] amt);
        control_t c;
        c = w_dp(op, s, wb);
        c.b_bus_source = B_IMM; c.b_bus_imm = imm;
        c.shift_source = SH_SRC_IMM; c.shift_type = SHIFT_ROR; c.shift_amount = amt;
        return c;
    endfunction

    function automatic control_t w_addr_imm(input alu_op_t op, input alu_wb_t wb, input logic [11:0] imm);
        control_t c;
        c = CTRL_NOP;
        c.b_bus_source = B_IMM; c.b_bus_imm = imm; c.alu_op = op; c.alu_writeback = wb;
        c.addr_bus_src = ADDR_ALU; c.incrementer_writeback = 1'b1;
        return c;
    endfunction

    localparam logic [31:0] I_ADD  = 32'hE2821005; // ADD r1,r2,#5
    localparam logic [31:0] I_RSR  = 32'hE0810312; // ADD r0,r1,r2,LSL r3
    localparam logic [31:0] I_LDR  = 32'hE5910004; // LDR r0,[r1,#4]
    localparam logic [31:0] I_CMP  = 32'hE3510000; // CMP r1,#0
    localparam logic [31:0] I_UND  = 32'hE7000010; // undefined space
    localparam logic [31:0] I_MOV  = 32'hE1A000C1; // MOV r0,r1,ASR #1
    localparam logic [31:0] I_STRR = 32'hE7210102; // STR r0,[r1,-r2,LSL #2]!
    localparam logic [31:0] I_STR  = 32'hE5810000; // STR r0,[r1]

    initial begin
        control_t nop_pc, rsr0, rsr1, ldr_wb, mov_rsi, strr_addr, st_rd, st_rd_wr, st_rd_pc;

        nop_pc = CTRL_NOP;
        nop_pc.addr_bus_src = ADDR_PC; nop_pc.incrementer_writeback = 1'b1;

        rsr0 = CTRL_NOP;
        rsr0.b_bus_source = B_REG_RS; rsr0.latch_shift_amt = 1'b1;

        rsr1 = w_dp(ALU_ADD, 1'b0, ALU_WB_REG_RD);
        rsr1.b_bus_source = B_REG_RM; rsr1.shift_source = SH_SRC_REG;
        rsr1.use_shift_latch = 1'b1; rsr1.shift_type = SHIFT_LSL;

        ldr_wb = CTRL_NOP;
        ldr_wb.b_bus_source = B_READ_DATA; ldr_wb.alu_op = ALU_MOV;
        ldr_wb.alu_writeback = ALU_WB_REG_RD; ldr_wb.addr_bus_src = ADDR_PC;

        mov_rsi = w_dp(ALU_MOV, 1'b0, ALU_WB_REG_RD);
        mov_rsi.b_bus_source = B_REG_RM; mov_rsi.shift_source = SH_SRC_IMM;
        mov_rsi.shift_type = SHIFT_ASR; mov_rsi.shift_amount = 5'd1;

        strr_addr = CTRL_NOP;
        strr_addr.b_bus_source = B_REG_RM; strr_addr.shift_source = SH_SRC_IMM;
        strr_addr.shift_type = SHIFT_LSL; strr_addr.shift_amount = 5'd2;
        strr_addr.alu_op = ALU_SUB; strr_addr.alu_writeback = ALU_WB_REG_RN;
        strr_addr.addr_bus_src = ADDR_ALU; strr_addr.incrementer_writeback = 1'b1;

        st_rd = CTRL_NOP;     st_rd.b_bus_source = B_REG_RD;
        st_rd_wr = st_rd;     st_rd_wr.memory_write_en = 1'b1;
        st_rd_pc = st_rd;     st_rd_pc.addr_bus_src = ADDR_PC;

        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; cond_pass = 1'b0; flush = 1'b0;

        // Reset state
        cyc(0, '0, 0, 0, mk(1, CTRL_NOP, 1, 0, 0));
        cyc(0, '0, 0, 0, mk(2, CTRL_NOP, 1, 0, 0));
        rst_n = 1'b1;

        // DP_IMM, then back-to-back DP_RSR, LDR offered while RSR is mid-sequence
        cyc(1, I_ADD, 1, 0, mk(3, CTRL_NOP, 1, 0, 0));
        cyc(1, I_RSR, 1, 0, mk(4, w_imm(ALU_ADD, 0, ALU_WB_REG_RD, 12'h005, 5'd0), 1, 1, 0));
        cyc(1, I_LDR, 1, 0, mk(5, rsr0, 0, 1, 0));
        cyc(1, I_LDR, 1, 0, mk(6, rsr1, 1, 1, 0));
        // LDR: ADDR, three MEM cycles, WB
        cyc(0, '0, 0, 0, mk(7,  w_addr_imm(ALU_ADD, ALU_WB_NONE, 12'h004), 0, 1, 0));
        cyc(0, '0, 0, 0, mk(8,  CTRL_NOP, 0, 1, 0));
        cyc(0, '0, 0, 0, mk(9,  CTRL_NOP, 0, 1, 0));
        cyc(0, '0, 0, 0, mk(10, CTRL_NOP, 0, 1, 0));
        cyc(0, '0, 0, 0, mk(11, ldr_wb, 1, 1, 0));
        // CMP with condition false, then true; UNDEF; DP_RSI
        cyc(1, I_CMP, 0, 0, mk(12, CTRL_NOP, 1, 0, 0));
        cyc(1, I_CMP, 1, 0, mk(13, nop_pc, 1, 1, 0));
        cyc(1, I_UND, 1, 0, mk(14, w_imm(ALU_CMP, 1, ALU_WB_NONE, 12'h000, 5'd0), 1, 1, 0));
        cyc(1, I_MOV, 1, 0, mk(15, nop_pc, 1, 1, 1));
        cyc(1, I_STRR, 1, 0, mk(16, mov_rsi, 1, 1, 0));
        // STR register offset, down, writeback
        cyc(0, '0, 0, 0, mk(17, strr_addr, 0, 1, 0));
        cyc(0, '0, 0, 0, mk(18, st_rd_wr, 0, 1, 0));
        cyc(0, '0, 0, 0, mk(19, st_rd, 0, 1, 0));
        cyc(0, '0, 0, 0, mk(20, st_rd_pc, 1, 1, 0));
        // Flush in the second LDR MEM cycle
        cyc(1, I_LDR, 1, 0, mk(21, CTRL_NOP, 1, 0, 0));
        cyc(0, '0, 0, 0, mk(22, w_addr_imm(ALU_ADD, ALU_WB_NONE, 12'h004), 0, 1, 0));
        cyc(0, '0, 0, 0, mk(23, CTRL_NOP, 0, 1, 0));
        cyc(1, I_ADD, 1, 1, mk(24, CTRL_NOP, 0, 1, 0));
        cyc(0, '0, 0, 0, mk(25, CTRL_NOP, 1, 0, 0));
        cyc(0, '0, 0, 0, mk(26, CTRL_NOP, 1, 0, 0));
        // Flush over a non-zero DP step
        cyc(1, I_ADD, 1, 0, mk(27, CTRL_NOP, 1, 0, 0));
        cyc(0, '0, 0, 1, mk(28, CTRL_NOP, 0, 1, 0));
        cyc(0, '0, 0, 0, mk(29, CTRL_NOP, 1, 0, 0));
        // Asynchronous reset in the middle of an STR
        cyc(1, I_STR, 1, 0, mk(30, CTRL_NOP, 1, 0, 0));
        cyc(0, '0, 0, 0, mk(31, w_addr_imm(ALU_ADD, ALU_WB_NONE, 12'h000), 0, 1, 0));
        cyc(0, '0, 0, 0, mk(32, st_rd_wr, 0, 1, 0));
        @(posedge clk);
        #1;
        instr_valid = 1'b0; instr = '0; cond_pass = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.push_back(mk(33, CTRL_NOP, 1, 0, 0));
        cyc(0, '0, 0, 0, mk(34, CTRL_NOP, 1, 0, 0));
        rst_n = 1'b1;
        cyc(1, I_ADD, 1, 0, mk(35, CTRL_NOP, 1, 0, 0));
        cyc(0, '0, 0, 0, mk(36, w_imm(ALU_ADD, 0, ALU_WB_REG_RD, 12'h005, 5'd0), 1, 1, 0));
        cyc(0, '0, 0, 0, mk(37, CTRL_NOP, 1, 0, 0));

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arm7_control_sequencer.md
Name: arm7_control_sequencer

Overview:
- Producer of the per-cycle `control_t` word defined in `control_types_pkg`. All datapath modules (register bank, B bus, barrel shifter, ALU, address, memory) consume this word.
- Accepts one decoded ARM instruction through a valid/ready handshake and expands it into a 1–N cycle sequence of control words.
- Sits between the fetch/IR stage and the datapath. The condition check happens upstream and arrives as `cond_pass`.

Parameters:
- `MEM_WAIT_STATES`, default 0: extra stall cycles (0–15) inserted in the LDR/STR memory step.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `instr` input 32: instruction word.
- `instr_valid` input 1: `instr` and `cond_pass` are valid.
- `cond_pass` input 1: condition field evaluated true against current flags.
- `instr_ready` output 1: sequencer accepts an instruction this cycle.
- `flush` input 1: abort the current sequence (pipeline refill).
- `ctrl` output `$bits(control_t)`: control word for the current cycle.
- `busy` output 1: a sequence is in progress.
- `undef` output 1: one-cycle pulse during the step of an unsupported instruction.

Behaviour:
- **Handshake.** Accept when `instr_valid && instr_ready`; this latches `instr`, `cond_pass`, and the decoded class. Step 0 drives `ctrl` in the next cycle, so latency is 1.
  - `instr_ready` = (state == IDLE) OR (final step of the current sequence). This gives back-to-back issue with no bubble.
- **Default control word.** `ctrl` is combinational from state and the latched IR. In IDLE it is all-zero: `*_NONE` sources, no writes, no latches. Every field not named below is zero.
- **Classes.** Decoded from `instr[27:25]` and bits 4/7:
  - DP_IMM: 001.
  - DP_RSI: 000 with `bit4`=0.
  - DP_RSR: 000 with `bit4`=1 and `bit7`=0.
  - LDR/STR: 010 or 011 with `bit4`=0, split by `bit20`.
  - Anything else: UNDEF.
- **Shared DP fields.**
  - `ALU_op`=`instr[24:21]`, using the `alu_op_t` encoding that matches the ARM opcode encoding.
  - `set_ALU_flags`=`instr[20]`.
  - `alu_writeback`=`ALU_WB_REG_RD`, except `ALU_WB_NONE` for opcodes 1000–1011.
  - `addr_bus_src`=PC, `incrementer_writeback`=1.
- **Sequences.**
  - **DP_IMM** (1 step): `B_bus_source`=IMM, `B_bus_imm`=`instr[11:0]`, `shift_source`=IMM, `shift_type`=ROR, `shift_amount`=`{instr[11:8],1'b0}`, plus the shared DP fields.
  - **DP_RSI** (1 step): `B_bus_source`=REG_RM, `shift_source`=IMM, `shift_type`=`instr[6:5]`, `shift_amount`=`instr[11:7]`, plus the shared DP fields.
  - **DP_RSR** (2 steps):
    - S0: `B_bus_source`=REG_RS, `latch_shift_amt`=1, no PC increment.
    - S1: `B_bus_source`=REG_RM, `shift_source`=REG, `use_shift_latch`=1, `shift_type`=`instr[6:5]`, plus the shared DP fields.
  - **LDR** (3 + `MEM_WAIT_STATES` steps):
    - ADDR: `B_bus_source`=IMM with `B_bus_imm`=`instr[11:0]`, or REG_RM with the DP_RSI shift fields if I=1. `ALU_op` = ADD if U=1, else SUB. `addr_bus_src`=ALU, `incrementer_writeback`=1, `alu_writeback`=`ALU_WB_REG_RN` iff W=1.
    - MEM: 1 + `MEM_WAIT_STATES` cycles, zero word. The wait counter loads `MEM_WAIT_STATES` on entry and decrements to 0.
    - WB: `B_bus_source`=READ_DATA, `ALU_op`=MOV, `alu_writeback`=RD, `addr_bus_src`=PC.
  - **STR** (2 + `MEM_WAIT_STATES` steps):
    - ADDR: same as LDR.
    - MEM: `B_bus_source`=REG_RD, `memory_write_en`=1 on the first MEM cycle only; final MEM cycle has `addr_bus_src`=PC.
  - **UNDEF or `cond_pass`=0** (1 step, NOP): `addr_bus_src`=PC, `incrementer_writeback`=1. `undef`=1 only for UNDEF with `cond_pass`=1.
- **States:** IDLE, STEP0, STEP1, MEMWAIT, WB. Transitions are fixed per class as above. The final step returns to IDLE, or to STEP0 if a new instruction is accepted in the same cycle.
- **Flush.** Highest priority. The next state is IDLE, `ctrl` is all-zero that cycle, and `instr_ready` is 0 in the flush cycle.
- **Reset.** Asynchronous to IDLE at any point, including mid-sequence. Reset values: `ctrl`=0, `busy`=0, `undef`=0, wait counter 0, `instr_ready`=1.

Optional Feature:
- Macro: `ARM7_SEQ_PERF_EN`.
- Defined: adds output ports `perf_instr_count[31:0]` and `perf_stall_count[31:0]`.
  - Instruction counter increments once per accepted instruction.
  - Stall counter increments each cycle with `busy`=1 and `instr_ready`=0.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Add `instr_class_t` (DP_IMM, DP_RSI, DP_RSR, LDR, STR, UNDEF) and `seq_state_t` to `control_types_pkg`.
- Add constant `CTRL_NOP` (the all-zero `control_t`) to `control_types_pkg`.
- One sub-module: `arm7_instr_classify`, a combinational `instr` → `instr_class_t` decoder.

Test Plan:
- `0xE2821005` (ADD r1,r2,#5), `cond_pass`=1:
  - Next cycle: IMM, `B_bus_imm`=0x005, `ALU_op`=ADD, `alu_writeback`=RD, `incrementer_writeback`=1.
  - `instr_ready` stays 1 throughout.
- `0xE0810312` (ADD r0,r1,r2,LSL r3):
  - Cycle 1: REG_RS with `latch_shift_amt`=1, `instr_ready`=0.
  - Cycle 2: REG_RM with `use_shift_latch`=1, `shift_type`=LSL, `instr_ready`=1.
- `0xE5910004` (LDR r0,[r1,#4]) with `MEM_WAIT_STATES`=2:
  - ADDR cycle: `addr_bus_src`=ALU, `B_bus_imm`=0x004.
  - Then 3 MEM cycles, then WB with READ_DATA → RD.
  - `instr_ready`=1 only in WB.
- `0xE3510000` (CMP r1,#0) with `cond_pass`=0: one NOP word, `undef`=0. Repeat with `cond_pass`=1: `alu_writeback`=NONE, `set_ALU_flags`=1.
- `flush` asserted in the second MEM cycle of an LDR: next cycle IDLE, `ctrl`=0, no WB word emitted.
- `rst_n` dropped mid-STR: all outputs reset immediately without waiting for `clk`. After release, a DP_IMM instruction issues cleanly.
